// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR: state encoding,
// default sizes, rounding constant and a width-parametrised signed clip.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fir_state_t;

    localparam int FIR_TAPS_DEF   = 57;
    localparam int FIR_DATA_W_DEF = 16;
    localparam int FIR_COEF_W_DEF = 16;
    localparam int FIR_FRAC_DEF   = 14;

    // Half an LSB of the output scale: added before the arithmetic shift.
    function automatic logic signed [63:0] fir_rnd(input int frac);
        return 64'sd1 <<< (frac - 1);
    endfunction

    function automatic logic signed [63:0] fir_sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Single signed MAC with clear, plus a registered round-half-up/saturate stage;
// result register doubles as the bypass holding register. No backpressure of its own.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W_DEF,
    parameter int COEF_W = FIR_COEF_W_DEF,
    parameter int FRAC   = FIR_FRAC_DEF,
    parameter int ACC_W  = 38
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_mac_en,
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic signed [COEF_W-1:0] i_coef,
    input  logic                     i_round,
    input  logic                     i_load,
    input  logic signed [DATA_W-1:0] i_load_dat,
    output logic signed [DATA_W-1:0] o_result
);

    localparam logic signed [ACC_W-1:0] RND = ACC_W'(fir_rnd(FRAC));

    logic signed [ACC_W-1:0]         r_acc;
    logic signed [DATA_W-1:0]        r_res;
    logic signed [DATA_W+COEF_W-1:0] w_prod;
    logic signed [ACC_W-1:0]         w_shift;

    assign w_prod  = i_sample * i_coef;
    assign w_shift = (r_acc + RND) >>> FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_res <= '0;
        end else begin
            if (i_clr)
                r_acc <= '0;
            else if (i_mac_en)
                r_acc <= r_acc + ACC_W'(w_prod);

            if (i_load)
                r_res <= i_load_dat;
            else if (i_round)
                r_res <= DATA_W'(fir_sat(64'(w_shift), DATA_W));
        end
    end

    assign o_result = r_res;

endmodule

// File: rtl/fir_tdm_filter.sv
// Time-multiplexed FIR, one tap per clock; out_valid TAPS+2 cycles after accept (1 in bypass).
// in_ready drops from accept until the output handshake; output held while out_ready is low.
module fir_tdm_filter
    import fir_pkg::*;
#(
    parameter int TAPS   = FIR_TAPS_DEF,
    parameter int DATA_W = FIR_DATA_W_DEF,
    parameter int COEF_W = FIR_COEF_W_DEF,
    parameter int FRAC   = FIR_FRAC_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      bypass,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      busy
);

    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int AW    = $clog2(TAPS);
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    fir_state_t               r_state;
    logic signed [DATA_W-1:0] r_hist [TAPS];
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic [AW-1:0]            r_wp;
    logic [AW-1:0]            r_idx;
    logic [AW-1:0]            r_k;
    logic                     r_out_vld;
    logic signed [DATA_W-1:0] r_out_dat;

    logic                     w_accept;
    logic                     w_coef_wr;
    logic signed [DATA_W-1:0] w_result;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_coef_wr = coef_we && (r_state == IDLE) && !in_valid && (int'(coef_addr) < TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wp      <= '0;
            r_idx     <= '0;
            r_k       <= '0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_hist[i] <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            if (w_coef_wr)
                r_coef[coef_addr] <= coef_data;

            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_hist[r_wp] <= in_data;
                        r_wp         <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
                        r_idx        <= r_wp;
                        r_k          <= '0;
                        r_state      <= bypass ? OUT : MAC;
                    end
                end
                MAC: begin
                    // Walk backwards from the newest sample while k walks forwards.
                    r_k   <= r_k + 1'b1;
                    r_idx <= (r_idx == '0) ? LAST : r_idx - 1'b1;
                    if (r_k == LAST)
                        r_state <= ROUND;
                end
                ROUND: r_state <= OUT;
                OUT: begin
                    if (!r_out_vld) begin
                        r_out_vld <= 1'b1;
                        r_out_dat <= w_result;
                    end else if (out_ready) begin
                        r_out_vld <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fir_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_accept && !bypass),
        .i_mac_en   (r_state == MAC),
        .i_sample   (r_hist[r_idx]),
        .i_coef     (r_coef[r_k]),
        .i_round    (r_state == ROUND),
        .i_load     (w_accept && bypass),
        .i_load_dat (in_data),
        .o_result   (w_result)
    );

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;

endmodule
